// File: rtl/tsc_pkg.sv
// tsc_pkg: shared types and constants for the time-set controller.
//   - tsc_state_e : controller state, encoded so it can be driven straight out
//                   as the 3-bit `field` indicator (0=RUN .. 7=COMMIT).
//   - *_W         : widths of the six calendar/time fields.
//   - *_MAX       : upper range limits, held at the common step width.
//   - days_in_month(year, month) : month length, with leap February on year[1:0]==0.
package tsc_pkg;

  localparam int YEAR_W  = 6;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  // All fields are stepped through one shared incrementer this wide.
  localparam int STEP_W  = 6;

  localparam logic [STEP_W-1:0] YEAR_MAX   = 6'd63;
  localparam logic [STEP_W-1:0] MONTH_MAX  = 6'd12;
  localparam logic [STEP_W-1:0] HOUR_MAX   = 6'd23;
  localparam logic [STEP_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_YEAR   = 3'd1,
    ST_MONTH  = 3'd2,
    ST_DAY    = 3'd3,
    ST_HOUR   = 3'd4,
    ST_MINUTE = 3'd5,
    ST_SECOND = 3'd6,
    ST_COMMIT = 3'd7
  } tsc_state_e;

  // Out-of-range months (0, 13..15) report 31 so a captured bad month never
  // shrinks the day range below what the day field may already hold.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [YEAR_W-1:0]  year,
                                                     input logic [MONTH_W-1:0] month);
    logic [DAY_W-1:0] dim;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/tsc_field_step.sv
// tsc_field_step: one-step wrap increment (and, with TSC_DEC_EN, decrement)
// of a field value against a [min, max] range.
//   value_i : current field value
//   min_i   : field minimum
//   max_i   : field maximum
//   inc_i   : step up, max wraps to min
//   dec_i   : step down, min wraps to max (only when TSC_DEC_EN is defined)
//   next_o  : stepped value (equals value_i when no step is requested)
// A value that lies outside [min, max] is replaced by min on any step, so a
// bad captured value is repaired the first time the user touches the field.
module tsc_field_step #(
  parameter int W = 6
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] min_i,
  input  logic [W-1:0] max_i,
  input  logic         inc_i,
`ifdef TSC_DEC_EN
  input  logic         dec_i,
`endif
  output logic [W-1:0] next_o
);

  localparam logic [W-1:0] ONE = 1;

  logic outOfRange;
  logic doInc;
  logic doDec;

  assign outOfRange = (value_i < min_i) || (value_i > max_i);

  // Simultaneous inc and dec cancel each other out.
`ifdef TSC_DEC_EN
  assign doInc = inc_i && !dec_i;
  assign doDec = dec_i && !inc_i;
`else
  assign doInc = inc_i;
  assign doDec = 1'b0;
`endif

  always_comb begin
    next_o = value_i;
    if (doInc) begin
      if (outOfRange || (value_i == max_i)) next_o = min_i;
      else                                  next_o = value_i + ONE;
    end else if (doDec) begin
      if (outOfRange)             next_o = min_i;
      else if (value_i == min_i)  next_o = max_i;
      else                        next_o = value_i - ONE;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: run gating and six-field edit session for the
// calendar/time-of-day counter.
//   clk, reset            : clock, asynchronous active-high reset
//   start / stop          : set / clear the run enable (stop wins)
//   mode                  : enter edit, advance field, or commit
//   inc                   : increment selected field
//   dec                   : decrement selected field (only with TSC_DEC_EN)
//   cur_*                 : live counter time, captured on edit entry
//   run                   : counter count enable (run_en while in RUN)
//   load                  : one-cycle parallel-load strobe (COMMIT state)
//   set_*                 : shadow time, valid whenever load is high
//   field                 : current state, 0=RUN .. 7=COMMIT
//   editing               : high in YEAR through SECOND
// Build option: define TSC_DEC_EN to add the `dec` port and decrement editing.
module time_set_controller
  import tsc_pkg::*;
#(
  parameter int LEAP_MOD4 = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               inc,
`ifdef TSC_DEC_EN
  input  logic               dec,
`endif
  input  logic [YEAR_W-1:0]  cur_year,
  input  logic [MONTH_W-1:0] cur_month,
  input  logic [DAY_W-1:0]   cur_day,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic [MIN_W-1:0]   cur_minute,
  input  logic [SEC_W-1:0]   cur_second,
  output logic               run,
  output logic               load,
  output logic [YEAR_W-1:0]  set_year,
  output logic [MONTH_W-1:0] set_month,
  output logic [DAY_W-1:0]   set_day,
  output logic [HOUR_W-1:0]  set_hour,
  output logic [MIN_W-1:0]   set_minute,
  output logic [SEC_W-1:0]   set_second,
  output logic [2:0]         field,
  output logic               editing
);

  tsc_state_e         state_q, state_d;
  logic               run_en_q, run_en_d;
  logic [YEAR_W-1:0]  set_year_q, set_year_d;
  logic [MONTH_W-1:0] set_month_q, set_month_d;
  logic [DAY_W-1:0]   set_day_q, set_day_d;
  logic [HOUR_W-1:0]  set_hour_q, set_hour_d;
  logic [MIN_W-1:0]   set_minute_q, set_minute_d;
  logic [SEC_W-1:0]   set_second_q, set_second_d;

  logic [YEAR_W-1:0]  dimYear;
  logic [DAY_W-1:0]   dim;
  logic [STEP_W-1:0]  stepVal;
  logic [STEP_W-1:0]  stepMin;
  logic [STEP_W-1:0]  stepMax;
  logic [STEP_W-1:0]  stepNext;
  logic               stepGo;

  // With leap years disabled, forcing year[0] high makes every year look
  // non-leap to days_in_month, so February is always 28.
  assign dimYear = (LEAP_MOD4 != 0) ? set_year_q : (set_year_q | 6'd1);
  assign dim     = days_in_month(dimYear, set_month_q);

`ifdef TSC_DEC_EN
  assign stepGo = inc | dec;
`else
  assign stepGo = inc;
`endif

  // Present the selected shadow field and its range to the shared stepper.
  always_comb begin
    stepVal = set_year_q;
    stepMin = '0;
    stepMax = YEAR_MAX;
    case (state_q)
      ST_MONTH: begin
        stepVal = {2'b00, set_month_q};
        stepMin = 6'd1;
        stepMax = MONTH_MAX;
      end
      ST_DAY: begin
        stepVal = {1'b0, set_day_q};
        stepMin = 6'd1;
        stepMax = {1'b0, dim};
      end
      ST_HOUR: begin
        stepVal = {1'b0, set_hour_q};
        stepMax = HOUR_MAX;
      end
      ST_MINUTE: begin
        stepVal = set_minute_q;
        stepMax = MINSEC_MAX;
      end
      ST_SECOND: begin
        stepVal = set_second_q;
        stepMax = MINSEC_MAX;
      end
      default: ;
    endcase
  end

  tsc_field_step #(.W(STEP_W)) u_step (
    .value_i (stepVal),
    .min_i   (stepMin),
    .max_i   (stepMax),
    .inc_i   (inc),
`ifdef TSC_DEC_EN
    .dec_i   (dec),
`endif
    .next_o  (stepNext)
  );

  // Next-state logic. run_en tracks start/stop in every state; it only
  // reaches the `run` output once the FSM is back in RUN. mode outranks any
  // field step in the same cycle.
  always_comb begin
    state_d      = state_q;
    run_en_d     = run_en_q;
    set_year_d   = set_year_q;
    set_month_d  = set_month_q;
    set_day_d    = set_day_q;
    set_hour_d   = set_hour_q;
    set_minute_d = set_minute_q;
    set_second_d = set_second_q;

    if (stop)       run_en_d = 1'b0;
    else if (start) run_en_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (mode) begin
          state_d      = ST_YEAR;
          set_year_d   = cur_year;
          set_month_d  = cur_month;
          set_day_d    = cur_day;
          set_hour_d   = cur_hour;
          set_minute_d = cur_minute;
          set_second_d = cur_second;
        end
      end
      ST_YEAR: begin
        if (mode)        state_d    = ST_MONTH;
        else if (stepGo) set_year_d = stepNext;
      end
      ST_MONTH: begin
        if (mode) begin
          state_d = ST_DAY;
          // The chosen month may be shorter than the captured day.
          if (set_day_q > dim) set_day_d = dim;
        end else if (stepGo) begin
          set_month_d = stepNext[MONTH_W-1:0];
        end
      end
      ST_DAY: begin
        if (mode)        state_d   = ST_HOUR;
        else if (stepGo) set_day_d = stepNext[DAY_W-1:0];
      end
      ST_HOUR: begin
        if (mode)        state_d    = ST_MINUTE;
        else if (stepGo) set_hour_d = stepNext[HOUR_W-1:0];
      end
      ST_MINUTE: begin
        if (mode)        state_d      = ST_SECOND;
        else if (stepGo) set_minute_d = stepNext;
      end
      ST_SECOND: begin
        if (mode)        state_d      = ST_COMMIT;
        else if (stepGo) set_second_d = stepNext;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State and shadow registers; reset abandons any session without a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      run_en_q     <= 1'b0;
      set_year_q   <= '0;
      set_month_q  <= 4'd1;
      set_day_q    <= 5'd1;
      set_hour_q   <= '0;
      set_minute_q <= '0;
      set_second_q <= '0;
    end else begin
      state_q      <= state_d;
      run_en_q     <= run_en_d;
      set_year_q   <= set_year_d;
      set_month_q  <= set_month_d;
      set_day_q    <= set_day_d;
      set_hour_q   <= set_hour_d;
      set_minute_q <= set_minute_d;
      set_second_q <= set_second_d;
    end
  end

  assign run        = run_en_q && (state_q == ST_RUN);
  assign load       = (state_q == ST_COMMIT);
  assign field      = state_q;
  assign editing    = (state_q != ST_RUN) && (state_q != ST_COMMIT);
  assign set_year   = set_year_q;
  assign set_month  = set_month_q;
  assign set_day    = set_day_q;
  assign set_hour   = set_hour_q;
  assign set_minute = set_minute_q;
  assign set_second = set_second_q;

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencing controller for the calendar/time-of-day counter. Gates the counter's run state from start/stop requests and runs a six-field edit session, year through second, driven by single-cycle `mode` and `inc` pulses. During a session it freezes the counter and edits shadow copies of the live time, then commits them with a one-cycle parallel-load pulse. It sits between the debounced front-panel inputs and the counter's run/load ports.

## Interface
Parameters:
- `LEAP_MOD4` (default 1): 1 means year values with `year[1:0]==0` are leap years; 0 means February is always 28 days.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sets the run enable.
- `stop`  in  1  one-cycle pulse; clears the run enable.
- `mode`  in  1  one-cycle pulse; enter edit, advance field, or commit.
- `inc`  in  1  one-cycle pulse; increment the selected field.
- `cur_year` / `cur_month` / `cur_day` / `cur_hour` / `cur_minute` / `cur_second`  in  6/4/5/5/6/6  live counter outputs.
- `run`  out  1  counter count enable.
- `load`  out  1  one-cycle parallel-load strobe to the counter.
- `set_year` / `set_month` / `set_day` / `set_hour` / `set_minute` / `set_second`  out  6/4/5/5/6/6  shadow values; valid whenever `load`=1.
- `field`  out  3  0=RUN, 1=YEAR, 2=MONTH, 3=DAY, 4=HOUR, 5=MINUTE, 6=SECOND, 7=COMMIT.
- `editing`  out  1  high in states YEAR through SECOND.

## Operation
- **States:** RUN → YEAR → MONTH → DAY → HOUR → MINUTE → SECOND → COMMIT → RUN.
- **RUN:**
  - `start` sets `run_en`; `stop` clears it.
  - `start` and `stop` in the same cycle: `stop` wins.
  - `mode` captures all `cur_*` into the shadows and moves to YEAR.
- **Edit states:**
  - `mode` advances to the next state.
  - `inc` increments the selected shadow field.
  - `mode` and `inc` in the same cycle: `mode` wins and `inc` is dropped.
  - `start` and `stop` are still recorded into `run_en`, but have no effect on `run` until COMMIT completes.
- **Field ranges and wrap:**
  - year 0..63, wraps 63→0.
  - month 1..12, wraps 12→1.
  - day 1..dim, wraps dim→1.
  - hour 0..23, minute 0..59, second 0..59, each wrapping to 0.
- **dim (days in month):**
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if leap, otherwise 28.
- **Clamping:**
  - On the MONTH→DAY transition, if `set_day` > dim, set `set_day` = dim.
  - A captured out-of-range value (e.g. month 0) is replaced by its field minimum on the first `inc` of that field; otherwise it is left unchanged.
- **COMMIT:** lasts one cycle. `load`=1 during it, then the state returns to RUN.
- **`run` output:** `run = run_en && state==RUN`.

## Timing
- **Reset values:**
  - State RUN, `run_en`=0, `run`=0, `load`=0, `field`=0, `editing`=0.
  - `set_year`=0, `set_month`=1, `set_day`=1, `set_hour`=0, `set_minute`=0, `set_second`=0.
- All outputs are registered or decoded directly from registered state.
- **Edit entry:**
  - `mode` in RUN at edge N: shadows equal the `cur_*` values sampled at edge N.
  - `field`=1 and `run`=0 from N+1.
- **`inc` at edge N:** the incremented value is visible from N+1.
- **Commit:**
  - `mode` in SECOND at edge N: `load`=1 during cycle N+1.
  - `field`=0 at N+2, and `run` = `run_en` from N+2.
- **Reset mid-edit:** abandons the session with no `load`, and all outputs take their reset values immediately (asynchronous).

## Configuration
- **`TSC_DEC_EN` defined:**
  - Adds input port `dec` (1 bit, one-cycle pulse), which decrements the selected field with reverse wrap: year 0→63, month 1→12, day 1→dim, hour 0→23, minute and second 0→59.
  - `inc` and `dec` in the same cycle: no change.
  - Priority is `mode` > (`inc` or `dec`).
- **`TSC_DEC_EN` not defined:** no `dec` port; only increment editing exists.

## Structure
- **Package `tsc_pkg`:**
  - State enum encoded per `field`.
  - Field width constants (6/4/5/5/6/6).
  - Range limits: 63, 12, 23, 59.
  - Function `days_in_month(year, month)`.
- **Sub-module `tsc_field_step`:** performs one field's wrap-increment (and decrement when enabled) against min/max inputs. It is instantiated once, with a mux selecting the field by state.

## Test plan
- Reset, pulse `start` → `run`=1 one cycle later. Pulse `stop` → `run`=0. `start` and `stop` together → `run`=0.
- Live time 10/2/28 13:59:59, `mode` then `mode` ×6 with no `inc` → `load` pulses once with shadows equal to the captured values; `run` restores to the prior `run_en`.
- Year 4, month 1, day 31: `mode`, `mode`, `inc` (month 2), `mode` → `set_day`=29. Repeat with year 5 → 28.
- In SECOND with `set_second`=59, `inc` → 0. In HOUR with 23, `inc` → 0.
- `mode` and `inc` in the same cycle in YEAR → field advances to MONTH and year is unchanged. Reset asserted in MINUTE → no `load`, all outputs at their reset values.
- With `TSC_DEC_EN`: in MONTH with `set_month`=1, `dec` → 12. `inc` and `dec` together → unchanged.
